// File: rtl/fwd_pkg.sv
// Shared constants for the EX-stage forwarding control: mux select encodings
// and the default register-number width.
package fwd_pkg;
    localparam logic [1:0] FWD_SRC_RF  = 2'b00;
    localparam logic [1:0] FWD_SRC_WB  = 2'b01;
    localparam logic [1:0] FWD_SRC_MEM = 2'b10;
    localparam int         REG_ADDR_W_DEF = 5;
endpackage

// File: rtl/fwd_sel_unit.sv
// Priority compare for one EX operand: the youngest in-flight producer wins,
// and register $0 is never forwarded.
module fwd_sel_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] ex_src,
    input  logic [REG_ADDR_W-1:0] mem_dst,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_dst,
    input  logic                  wb_regwrite,
    output logic [1:0]            sel
);
    always_comb begin
        sel = FWD_SRC_RF;
        if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_src))
            sel = FWD_SRC_MEM;
        else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_src))
            sel = FWD_SRC_WB;
    end
endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding-mux select and load-use stall control. Tracks register tags of
// the instructions in EX, MEM and WB in a shadow pipeline.
module forward_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] id_dst_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);
    localparam int NUM_OPS = 2;

    logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic                  ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
    logic                  hazard, load_id;

    logic [NUM_OPS-1:0][REG_ADDR_W-1:0] ex_src;
    logic [NUM_OPS-1:0][1:0]            fwd_sel;

    assign hazard = ex_memread && (ex_dst != '0) && id_valid_i &&
                    ((ex_dst == id_rs_i) || (id_uses_rt_i && (ex_dst == id_rt_i)));
    // A taken branch squashes the consumer, so there is nothing to stall for.
    assign stall_o = hazard && !flush_i;
    assign load_id = id_valid_i && !stall_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_dst       <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_dst      <= '0;
            mem_regwrite <= 1'b0;
            wb_dst       <= '0;
            wb_regwrite  <= 1'b0;
        end else begin
            wb_dst       <= mem_dst;
            wb_regwrite  <= mem_regwrite;
            mem_dst      <= ex_dst;
            mem_regwrite <= ex_regwrite;
            if (load_id) begin
                ex_rs       <= id_rs_i;
                ex_rt       <= id_rt_i;
                ex_dst      <= id_dst_i;
                ex_regwrite <= id_regwrite_i;
                ex_memread  <= id_memread_i;
            end else begin
                ex_rs       <= '0;
                ex_rt       <= '0;
                ex_dst      <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_cnt_o <= '0;
        else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}}))
            stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign ex_src[0] = ex_rs;
    assign ex_src[1] = ex_rt;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_sel
        fwd_sel_unit #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
            .ex_src      (ex_src[g]),
            .mem_dst     (mem_dst),
            .mem_regwrite(mem_regwrite),
            .wb_dst      (wb_dst),
            .wb_regwrite (wb_regwrite),
            .sel         (fwd_sel[g])
        );
    end

    assign fwd_a_o = fwd_sel[0];
    assign fwd_b_o = fwd_sel[1];
endmodule
